// File: rtl/hazard_ctl.sv
// Stage-2 hazard/stall controller: RAW scoreboard, memory-latency tracker, watchdog.
// Optional saturating stall counter behind HAZARD_STATS_EN (tied to zero when undefined).
module hazard_ctl #(
   parameter logic [5:0] NOP_C    = 6'b100011,
   parameter logic [5:0] NOP_B    = 6'b111111,
   parameter logic [5:0] MDR_IDX  = 6'd4,
   parameter int         MEM_LAT  = 2,
   parameter int         MAX_HOLD = 15
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic [5:0]  B2,
   input  logic [5:0]  C2,
   input  logic [1:0]  M2,
   output logic        HOLD,
   output logic        MEM_BUSY,
   output logic        ERR,
   output logic [15:0] STALL_CNT
);

   localparam logic [2:0] LAT3  = 3'(MEM_LAT);
   localparam logic [7:0] MAXH8 = 8'(MAX_HOLD);

   typedef enum logic {RUN, MWAIT} state_t;

   state_t     state, state_nxt;
   logic [2:0] mcnt, mcnt_nxt;
   logic [5:0] d3, d4;
   logic [7:0] hcnt, hcnt_nxt;
   logic       raw, mdr, strct;

   always_comb begin
      raw   = (B2 != NOP_B) &&
              (((B2 == d3) && (d3 != NOP_C)) || ((B2 == d4) && (d4 != NOP_C)));
      mdr   = (state == MWAIT) && (B2 == MDR_IDX);
      strct = (state == MWAIT) && (M2 != 2'b00);
      HOLD  = raw | mdr | strct;
   end

   assign MEM_BUSY = (state == MWAIT);

   // A held memory op never starts an access; it retries once it proceeds.
   always_comb begin
      state_nxt = state;
      mcnt_nxt  = mcnt;
      case (state)
         RUN: begin
            if ((M2 != 2'b00) && !HOLD) begin
               state_nxt = MWAIT;
               mcnt_nxt  = LAT3;
            end
         end
         MWAIT: begin
            mcnt_nxt = mcnt - 3'd1;
            if (mcnt == 3'd1) state_nxt = RUN;
         end
      endcase
   end

   always_comb begin
      if (!HOLD)             hcnt_nxt = 8'd0;
      else if (hcnt == 8'hFF) hcnt_nxt = hcnt;
      else                   hcnt_nxt = hcnt + 8'd1;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= RUN;
         mcnt  <= 3'd0;
         d3    <= NOP_C;
         d4    <= NOP_C;
         hcnt  <= 8'd0;
         ERR   <= 1'b0;
      end else begin
         state <= state_nxt;
         mcnt  <= mcnt_nxt;
         d3    <= HOLD ? NOP_C : C2;
         d4    <= d3;
         hcnt  <= hcnt_nxt;
         if (HOLD && (hcnt_nxt == MAXH8)) ERR <= 1'b1;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_q;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)                            stall_q <= 16'h0000;
      else if (HOLD && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
   end

   assign STALL_CNT = stall_q;
`else
   assign STALL_CNT = 16'h0000;
`endif

endmodule

// File: doc/hazard_ctl.md
# hazard_ctl

Hazard and stall controller for the pipelined microprogrammed datapath. It watches the micro-instruction fields in stage 2 (B source, C destination, M memory control) and drives HOLD into the stage-3 pipeline register. When HOLD is high, that register loads a bubble and stages 1–2 freeze. The block keeps its own destination scoreboard for stages 3–4, a memory-latency tracker and an optional stall counter.

## Interface
Parameters:
- NOP_C, 6'b100011, C-field code meaning "no register write" (the bubble destination)
- NOP_B, 6'b111111, B-field code meaning "no B-bus read"
- MDR_IDX, 6'd4, B/C code of the MDR register
- MEM_LAT, 2, cycles from read issue until MDR holds valid data (1..7)
- MAX_HOLD, 15, consecutive HOLD cycles before ERR sets (1..255)

Ports:
- CLK  in  1  sole clock, rising edge
- RSTN  in  1  asynchronous, active-low reset
- B2  in  6  B-bus source of the stage-2 micro-op
- C2  in  6  destination of the stage-2 micro-op
- M2  in  2  memory control of the stage-2 micro-op: [1]=read, [0]=write
- HOLD  out  1  freeze stages 1–2 and insert a bubble at stage 3
- MEM_BUSY  out  1  a memory access is in flight
- ERR  out  1  sticky watchdog flag
- STALL_CNT  out  16  saturating count of HOLD cycles (HAZARD_STATS_EN only)

## Operation
- Scoreboard: registers D3 and D4 model the destinations in stages 3 and 4.
  - Each edge: D3 ← (HOLD ? NOP_C : C2), then D4 ← D3.
  - Reset value of both: NOP_C.
- RAW hazard (raw): B2 ≠ NOP_B, and B2 equals D3 or D4, where that D ≠ NOP_C.
- Memory FSM, states RUN and MWAIT, with a 3-bit counter MCNT:
  - RUN → MWAIT when M2 ≠ 0 and HOLD = 0 at the edge. MCNT ← MEM_LAT.
  - In MWAIT, MCNT decrements each edge. MWAIT → RUN on the edge where MCNT goes 1 → 0.
  - MEM_BUSY = (state == MWAIT).
- Memory hazards, active only in MWAIT:
  - mdr: B2 == MDR_IDX.
  - struct: M2 ≠ 0, i.e. a second access while one is in flight.
- HOLD = raw | mdr | struct. It is combinational from the current inputs and registered state, and is never registered.
- Write-only accesses (M2 = 01) also occupy MWAIT for MEM_LAT cycles. They do not create an mdr hazard on their own, but mdr is evaluated whenever the state is MWAIT.
- Watchdog:
  - 8-bit counter HCNT increments each edge with HOLD = 1 and clears on HOLD = 0.
  - When HCNT reaches MAX_HOLD, ERR ← 1. ERR clears only by reset.
  - HOLD is not forced low by ERR.
- Reset values: HOLD = 0 (D3, D4 = NOP_C, state RUN), MEM_BUSY = 0, ERR = 0, STALL_CNT = 0, MCNT = 0, HCNT = 0.

## Timing
- HOLD reacts in the same cycle as the B2/C2/M2 change. The downstream pipeline register samples it on the next rising edge.
- RAW stall lengths (no forwarding):
  - Dependency on the immediately preceding op: 2 bubbles.
  - Dependency one op back: 1 bubble.
- MDR read-after-read: read issued at edge k. A dependent op in stage 2 stalls until the edge k+MEM_LAT, then proceeds in the following cycle.
- Simultaneous events:
  - raw and memory hazards together: one HOLD, counted once.
  - A memory op that is itself held does not enter MWAIT.
- Reset asserted mid-access:
  - FSM goes to RUN and the scoreboard is cleared immediately; HOLD drops asynchronously.
  - The in-flight access is abandoned, with no later MWAIT exit.
- STALL_CNT increments on each edge with HOLD = 1 and saturates at 16'hFFFF.

## Configuration
- HAZARD_STATS_EN:
  - Defined: STALL_CNT is implemented as described.
  - Undefined: no counter flops; STALL_CNT is tied to 16'h0000.
- HOLD, MEM_BUSY and ERR behave identically in both builds.

## Test plan
- Reset with RSTN = 0 and B2 = 6'd1 → HOLD = 0, MEM_BUSY = 0, ERR = 0, STALL_CNT = 0.
- Issue C2 = 6'd5, then next cycle B2 = 6'd5 → HOLD high for exactly 2 cycles, then the op passes; STALL_CNT = 2.
- C2 = 6'd5, one unrelated op, then B2 = 6'd5 → HOLD high 1 cycle. Same sequence with C2 = NOP_C → HOLD never asserts.
- With MEM_LAT = 2: M2 = 2'b10, then B2 = MDR_IDX next cycle → MEM_BUSY high 2 cycles; HOLD high while MEM_BUSY; the dependent op issues when MEM_BUSY falls. Back-to-back M2 = 2'b01 → second access held until RUN.
- Hold B2 = 6'd5 against a stuck D3 = 6'd5 with MAX_HOLD = 3 → ERR = 1 after the 3rd held edge; it stays 1 after the hazard clears, until RSTN.
- Assert RSTN = 0 during MWAIT → MEM_BUSY = 0 and HOLD = 0 immediately. After release, B2 = MDR_IDX → no HOLD.
